// File: rtl/seq_issue_pkg.sv
// Shared definitions for the seq issue controller.
// Opcodes, instruction field positions and issue FSM encoding.
package seq_issue_pkg;

    localparam int INST_W = 8;

    localparam logic [1:0] OP_PUSH = 2'd0;
    localparam logic [1:0] OP_ADD  = 2'd1;
    localparam logic [1:0] OP_MULT = 2'd2;
    localparam logic [1:0] OP_SEND = 2'd3;

    localparam int OP_HI  = 7;
    localparam int OP_LO  = 6;
    localparam int RA_HI  = 5;
    localparam int RA_LO  = 4;
    localparam int RB_HI  = 3;
    localparam int RB_LO  = 2;
    localparam int RC_HI  = 1;
    localparam int RC_LO  = 0;
    localparam int IMM_HI = 3;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    // Register written by an instruction; send writes nothing.
    function automatic logic [1:0] dest_reg(input logic [7:0] inst);
        if (inst[OP_HI:OP_LO] == OP_PUSH)
            return inst[RA_HI:RA_LO];
        return inst[RC_HI:RC_LO];
    endfunction

    // True when the instruction reads register r.
    function automatic logic reads_reg(input logic [7:0] inst,
                                       input logic [1:0] r);
        logic [1:0] op;
        op = inst[OP_HI:OP_LO];
        if (op == OP_ADD || op == OP_MULT)
            return (inst[RA_HI:RA_LO] == r) || (inst[RB_HI:RB_LO] == r);
        if (op == OP_SEND)
            return inst[RA_HI:RA_LO] == r;
        return 1'b0;
    endfunction

endpackage

// File: rtl/seq_issue_fifo.sv
// Synchronous instruction FIFO with occupancy count.
// Pointers wrap modulo DEPTH; full/empty come from the registered count.
module seq_issue_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [W-1:0]             wr_data,
    input  logic                     wr_en,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push    = wr_en & ~full;
    assign pop     = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/seq_issue.sv
// Issue controller feeding the seq datapath from a small FIFO.
// Run/step FSM, send-vs-busy stall and one-bubble RAW hazard interlock.
module seq_issue #(
    parameter int INST_W = seq_issue_pkg::INST_W,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INST_W-1:0]        i_wr_inst,
    input  logic                     i_wr_valid,
    output logic                     o_wr_ready,
    input  logic                     i_run,
    input  logic                     i_step,
    input  logic                     i_tx_busy,
    output logic [INST_W-1:0]        o_inst,
    output logic                     o_inst_valid,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [CNT_W-1:0]         o_issued_cnt,
    output logic [CNT_W-1:0]         o_stall_cnt
);

    import seq_issue_pkg::*;

    state_t             state;
    state_t             state_nxt;
    logic [INST_W-1:0]  head;
    logic               full;
    logic               active;
    logic               hazard;
    logic               busy_blk;
    logic               can_issue;
    logic               last_wr_vld;
    logic [1:0]         last_wr_reg;

    seq_issue_fifo #(
        .W     (INST_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_data (i_wr_inst),
        .wr_en   (i_wr_valid),
        .rd_en   (can_issue),
        .rd_data (head),
        .count   (o_count),
        .full    (full),
        .empty   (o_empty)
    );

    assign o_wr_ready   = ~full;
    assign o_inst_valid = can_issue;
    assign o_inst       = o_empty ? '0 : head;

    // Eligibility of the FIFO head this cycle.
    always_comb begin
        active    = (state == ST_RUN) || (state == ST_STEP);
        busy_blk  = (head[OP_HI:OP_LO] == OP_SEND) && i_tx_busy;
        hazard    = last_wr_vld && reads_reg(head[7:0], last_wr_reg);
        can_issue = active && !o_empty && !busy_blk && !hazard;
    end

    // Next-state logic for run/step control.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (i_run)
                    state_nxt = ST_RUN;
                else if (i_step)
                    state_nxt = ST_STEP;
            end
            ST_RUN: begin
                if (!i_run)
                    state_nxt = ST_IDLE;
            end
            ST_STEP: begin
                if (can_issue)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Remember last cycle's write-back target for the hazard check.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_wr_vld <= 1'b0;
            last_wr_reg <= '0;
        end else if (can_issue && head[OP_HI:OP_LO] != OP_SEND) begin
            last_wr_vld <= 1'b1;
            last_wr_reg <= dest_reg(head[7:0]);
        end else begin
            last_wr_vld <= 1'b0;
            last_wr_reg <= '0;
        end
    end

    // Issue and stall statistics, free-running with wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_issued_cnt <= '0;
            o_stall_cnt  <= '0;
        end else begin
            if (can_issue)
                o_issued_cnt <= o_issued_cnt + 1'b1;
            if (active && !o_empty && !can_issue)
                o_stall_cnt <= o_stall_cnt + 1'b1;
        end
    end

endmodule

// File: doc/seq_issue.md
# seq_issue

Instruction issue controller for the `seq` sequencer datapath. It buffers instructions from the host or UART receive side in a small FIFO and presents them to `seq` one at a time. Issue follows a run/step control state machine. The block stalls a `send` while the UART transmitter is busy and inserts a one-cycle bubble on read-after-write hazards against the datapath's registered ALU write-back.

## Interface
Parameters:
- `INST_W`, 8: instruction width. Fields: op `[7:6]`, ra `[5:4]`, rb `[3:2]`, rc `[1:0]`, imm `[3:0]`.
- `DEPTH`, 8: FIFO entries; must be a power of 2, ≥ 2.
- `CNT_W`, 16: width of the statistics counters.

Ports (clock and reset first):
- `clk` input 1: single clock; all logic rising-edge.
- `rst` input 1: asynchronous, active-low reset.
- `i_wr_inst` input INST_W: instruction to enqueue.
- `i_wr_valid` input 1: enqueue request; accepted when `o_wr_ready`.
- `o_wr_ready` input-side output 1: FIFO not full.
- `i_run` input 1: level; continuous issue while high.
- `i_step` input 1: pulse; issue exactly one instruction when idle.
- `i_tx_busy` input 1: UART transmitter busy; the same signal that drives `seq`.
- `o_inst` output INST_W: instruction to `seq` (drives `i_inst`).
- `o_inst_valid` output 1: one-cycle issue strobe to `seq` (drives `i_inst_valid`).
- `o_empty` output 1: FIFO empty.
- `o_count` output $clog2(DEPTH)+1: FIFO occupancy.
- `o_issued_cnt` output CNT_W: instructions issued; wraps.
- `o_stall_cnt` output CNT_W: cycles where the head was blocked by a busy or hazard condition; wraps.

## Operation
- Opcodes: push=0, add=1, mult=2, send=3.
- Destination register: push writes ra; add and mult write rc; send writes nothing.
- Sources: add and mult read ra and rb; send reads ra; push reads nothing.
- FIFO:
  - Write is accepted iff `i_wr_valid & o_wr_ready`.
  - `o_wr_ready = (count != DEPTH)`, evaluated on registered count; it does not look ahead to a same-cycle pop.
  - Simultaneous write and pop: count is unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: from `i_run` → RUN; from `i_step` → STEP. If both are asserted, `i_run` wins.
  - RUN: issue when eligible. When `i_run` falls → IDLE; an in-flight eligible issue in that same cycle still occurs.
  - STEP: wait until one instruction issues, then → IDLE. An empty FIFO holds STEP until an instruction arrives.
- Eligibility (`can_issue`) requires all of:
  - state is RUN or STEP;
  - FIFO not empty;
  - if the head is a send, `~i_tx_busy`;
  - no hazard.
- Hazard: the previous cycle issued a push, add or mult whose destination equals a source of the head.
- Hazard tracking registers `last_wr_vld` and `last_wr_reg` are updated every cycle from the issued instruction; they are cleared when nothing issues.
- Issue: `o_inst_valid = can_issue`, `o_inst = head`. The head pops on the same edge. `o_inst` equals the head whenever the FIFO is non-empty, and 0 when it is empty.
- `o_stall_cnt` increments when state is RUN or STEP, the FIFO is non-empty, and `can_issue` is 0.

## Timing
- Reset (asynchronous, active-low):
  - FIFO flushed; `o_count` = 0, `o_empty` = 1, `o_wr_ready` = 1.
  - `o_inst_valid` = 0, `o_inst` = 0.
  - Both counters = 0; hazard registers cleared; FSM → IDLE.
  - Reset mid-run drops all queued instructions with no issue pulse.
- Enqueue-to-issue latency: minimum 1 cycle. A write into an empty FIFO at edge N becomes issuable in cycle N+1.
- Throughput: one instruction per cycle when there are no hazards and no busy stalls.
- A hazard costs exactly one bubble, since the datapath write-back has 1-cycle latency.
- A send that is stalled by busy issues in the first cycle `i_tx_busy` = 0.

## Structure
- Shared package (extending the `seq` definitions): opcode constants, field bit positions, `INST_W`, and FSM state encoding.
- Sub-module `seq_issue_fifo`: a synchronous FIFO with `DEPTH`, count, full and empty outputs.
- The FSM, hazard logic and counters live in the top level.

## Test plan
- **Basic issue:** reset, enqueue 0x15 (push r1,5), assert `i_run` → `o_inst_valid` for 1 cycle with `o_inst` = 0x15, `o_issued_cnt` = 1.
- **Hazard bubble:** enqueue 0x15 then 0x56 (add r2 = r1 + r1) → the second issues 2 cycles after the first; `o_stall_cnt` = 1.
- **Busy stall:** enqueue 0xE0 (send r2) with `i_tx_busy` = 1 for 5 cycles → no issue for those 5 cycles, issue in the cycle busy drops; `o_stall_cnt` = 5.
- **Full FIFO:** enqueue 9 instructions while in IDLE → 8 accepted, `o_wr_ready` = 0, `o_count` = 8; the 9th is ignored.
- **Step mode:** with 3 queued, pulse `i_step` twice → exactly 2 issues, FSM returns to IDLE, `o_count` = 1.
- **Async reset mid-run:** with 4 queued and running, assert `rst` low → `o_count` = 0 and `o_inst_valid` = 0 immediately; no issues until re-run.
